// File: rtl/async_in_pkg.sv
// async_in_pkg: shared FSM state encoding and parameter defaults for the input conditioner
package async_in_pkg;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int FILTER_CYCLES_DEF = 3;
  localparam int CNT_W_DEF = 8;
  typedef enum logic [1:0] {ST_LOW, ST_QUAL_HI, ST_HIGH, ST_QUAL_LO} state_t;
endpackage

// File: rtl/sync_nff.sv
// sync_nff: N-flop synchronizer for an asynchronous single-bit input
module sync_nff #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic [N-1:0] r;
  always_ff @(posedge clk or posedge reset)
    if (reset) r <= '0;
    else r <= {r[N-2:0], d};
  assign q = r[N-1];
endmodule

// File: rtl/async_in_conditioner.sv
// async_in_conditioner: synchronizes, glitch-filters and edge-counts an asynchronous input
module async_in_conditioner
  import async_in_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int FILTER_CYCLES = FILTER_CYCLES_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             d_in,
  input  logic             en,
  input  logic             clr_cnt,
  output logic             q_out,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] edge_cnt,
  output logic             cnt_sat
);
  localparam logic [3:0] FC_LAST = 4'(FILTER_CYCLES - 1);
  logic s_in;
  state_t state;
  logic [3:0] fcnt;
  logic rise, fall;
  sync_nff #(.N(SYNC_STAGES)) u_sync (.clk(clk), .reset(reset), .d(d_in), .q(s_in));
  // fcnt counts qualifying samples already seen; the current one completes the run
  always_comb begin
    rise = en && s_in && ((state == ST_LOW && FILTER_CYCLES == 1) || (state == ST_QUAL_HI && fcnt == FC_LAST));
    fall = en && !s_in && ((state == ST_HIGH && FILTER_CYCLES == 1) || (state == ST_QUAL_LO && fcnt == FC_LAST));
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= ST_LOW;
      fcnt <= '0;
      q_out <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      rise_pulse <= rise;
      fall_pulse <= fall;
      q_out <= rise ? 1'b1 : fall ? 1'b0 : q_out;
      case (state)
        ST_LOW:
          if (en && s_in) begin
            state <= rise ? ST_HIGH : ST_QUAL_HI;
            fcnt <= 4'd1;
          end
        ST_QUAL_HI:
          if (!en || !s_in) state <= ST_LOW;
          else if (rise) state <= ST_HIGH;
          else fcnt <= fcnt + 4'd1;
        ST_HIGH:
          if (en && !s_in) begin
            state <= fall ? ST_LOW : ST_QUAL_LO;
            fcnt <= 4'd1;
          end
        ST_QUAL_LO:
          if (!en || s_in) state <= ST_HIGH;
          else if (fall) state <= ST_LOW;
          else fcnt <= fcnt + 4'd1;
      endcase
    end
  // clear takes priority over a coincident accepted edge
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      edge_cnt <= '0;
      cnt_sat <= 1'b0;
    end else if (clr_cnt) begin
      edge_cnt <= '0;
      cnt_sat <= 1'b0;
    end else if ((rise || fall) && !(&edge_cnt)) begin
      edge_cnt <= edge_cnt + CNT_W'(1);
      cnt_sat <= cnt_sat | (&(edge_cnt + CNT_W'(1)));
    end
endmodule

// File: tb/tb_async_in_conditioner.sv
// tb_async_in_conditioner: directed and random stimulus checked against a run-length reference model
module tb_async_in_conditioner;
  localparam int NS = 2;
  localparam int FC = 3;
  localparam int CW = 3;
  localparam int CMAX = (1 << CW) - 1;
  logic clk = 1'b1;
  logic reset = 1'b0;
  logic d_in = 1'b0;
  logic en = 1'b1;
  logic clr_cnt = 1'b0;
  logic q_out, rise_pulse, fall_pulse, cnt_sat;
  logic [CW-1:0] edge_cnt;
  int checks = 0;
  int failures = 0;
  bit mq[$];
  bit mlev, mrise, mfall, msat;
  int run, mcnt;

  always #5 clk = ~clk;

  async_in_conditioner #(.SYNC_STAGES(NS), .FILTER_CYCLES(FC), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .d_in(d_in), .en(en), .clr_cnt(clr_cnt),
    .q_out(q_out), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
    .edge_cnt(edge_cnt), .cnt_sat(cnt_sat)
  );

  function void mreset();
    mq.delete();
    for (int i = 0; i < NS; i++) mq.push_back(1'b0);
    mlev = 0; mrise = 0; mfall = 0; msat = 0; run = 0; mcnt = 0;
  endfunction

  // reference: d_in appears NS edges later; a change is accepted once FC consecutive enabled samples differ from the level
  function void mstep(bit d, bit e, bit c);
    bit s;
    s = mq.pop_front();
    mq.push_back(d);
    mrise = 0;
    mfall = 0;
    if (e && s != mlev) begin
      run++;
      if (run == FC) begin
        mlev = s;
        mrise = s;
        mfall = !s;
        run = 0;
      end
    end else run = 0;
    if (c) begin
      mcnt = 0;
      msat = 0;
    end else if ((mrise || mfall) && mcnt < CMAX) begin
      mcnt++;
      if (mcnt == CMAX) msat = 1;
    end
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s at %0t: observed=%0h expected=%0h", tag, $time, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    chk({tag, "/q_out"}, 32'(q_out), 32'(mlev));
    chk({tag, "/rise"}, 32'(rise_pulse), 32'(mrise));
    chk({tag, "/fall"}, 32'(fall_pulse), 32'(mfall));
    chk({tag, "/edge_cnt"}, 32'(edge_cnt), 32'(mcnt));
    chk({tag, "/cnt_sat"}, 32'(cnt_sat), 32'(msat));
  endtask

  task automatic step(bit d, bit e, bit c, string tag);
    d_in = d;
    en = e;
    clr_cnt = c;
    @(posedge clk);
    mstep(d, e, c);
    #1;
    check_all(tag);
  endtask

  task automatic pulse_reset(string tag);
    reset = 1'b1;
    #2;
    mreset();
    check_all(tag);
    reset = 1'b0;
  endtask

  initial begin
    mreset();
    reset = 1'b1;
    #1;
    check_all("reset_hold");
    #24;
    reset = 1'b0;
    repeat (18) step(0, 1, 0, "idle");
    repeat (7) step(1, 1, 0, "rise_latency");
    repeat (2) step(0, 1, 0, "fall_glitch");
    repeat (6) step(1, 1, 0, "fall_glitch_hold");
    repeat (8) step(0, 1, 0, "fall_accept");
    repeat (2) step(1, 1, 0, "rise_glitch");
    repeat (6) step(0, 1, 0, "rise_glitch_hold");
    repeat (3) step(1, 1, 0, "rise_min");
    repeat (6) step(0, 1, 0, "rise_min_hold");
    for (int i = 0; i < 15; i++) step(bit'((i / 3) % 2), 0, 0, "en_off");
    repeat (8) step(1, 1, 0, "en_on");
    repeat (8) step(0, 1, 1, "clr_vs_edge");
    repeat (10) begin
      repeat (5) step(1, 1, 0, "sat_hi");
      repeat (5) step(0, 1, 0, "sat_lo");
    end
    step(0, 1, 1, "sat_clear");
    repeat (3) step(0, 1, 0, "after_clear");
    repeat (3) step(1, 1, 0, "qual_before_reset");
    pulse_reset("reset_mid_qual");
    repeat (8) step(0, 1, 0, "post_reset_low");
    repeat (3) step(1, 1, 0, "qual_before_reset2");
    pulse_reset("reset_mid_qual2");
    repeat (8) step(1, 1, 0, "post_reset_high");
    repeat (120) begin
      bit d;
      d = bit'($urandom_range(0, 1));
      repeat ($urandom_range(1, 5))
        step(d, $urandom_range(0, 7) != 0, $urandom_range(0, 15) == 0, "random");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
